alu_core: RTL and testbench
===========================

# alu_core

Single-cycle registered arithmetic/logic unit for the CSM datapath on the Fomu FPGA target. Each clock it applies a 4-bit operation to two WIDTH-bit operands and registers the result on `o_data`, one clock after the operands are presented. It carries no flags and does no stalling. The controller sequences ops back-to-back and reads each result on the following cycle.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal values are 4 to 32.
- `i_clk`, input, 1 bit: system clock; all state changes on its rising edge.
- `i_rst`, input, 1 bit: reset, asynchronous and active-high.
- `i_op`, input, 4 bits: operation code.
- `i_arg0`, input, WIDTH bits: first operand.
- `i_arg1`, input, WIDTH bits: second operand.
- `o_data`, output, WIDTH bits: registered result.

## Operation
Op-code encodings and the result `o_data` takes on the next rising edge:
- 0x0 `NO_OP`: `o_data` holds its value.
- 0x1 `ADD_OP`: arg0 + arg1, modulo 2^WIDTH; carry is discarded.
- 0x2 `SUB_OP`: arg0 − arg1, modulo 2^WIDTH; two's-complement wrap (8 − 13 = 0xFB).
- 0x3 `MUL_OP`: low WIDTH bits of arg0 × arg1. This is identical for signed and unsigned operands.
- 0x4 `AND_OP`: bitwise arg0 & arg1.
- 0x5 `OR_OP`: bitwise arg0 | arg1.
- 0x6 `XOR_OP`: bitwise arg0 ^ arg1.
- 0x7 `ROL_OP`: arg0 rotated left by one bit, so the MSB moves to bit 0. arg1 is ignored.
- 0x8 `ROR_OP`: arg0 rotated right by one bit. arg1 is ignored.
- 0x9 `LSL_OP`: arg0 << 1, zero fill. arg1 is ignored.
- 0xA `LSR_OP`: arg0 >> 1, zero fill. arg1 is ignored.
- 0xB `ASR_OP`: arg0 >> 1, sign fill. arg1 is ignored.
- 0xC `NOT_OP`: bitwise ~arg0. arg1 is ignored.
- 0xD–0xF: reserved; they behave exactly as `NO_OP` (hold).

Additional rules:
- All arithmetic is modulo 2^WIDTH. No overflow or carry output exists.
- Operands are sampled only at the clock edge. Input changes between edges have no effect.

## Timing
- Latency is exactly one clock. Operands and op present before edge N produce their result on `o_data` after edge N.
- Throughput is one op per clock. Back-to-back ops each appear on consecutive cycles.
- Multiply is combinational within the single cycle; no multi-cycle path and no busy signal.
- `o_data` is driven purely from a register; there is no combinational path from inputs to output.
- Reset value: `o_data` = 0.
- Asserting `i_rst` clears `o_data` immediately, independent of the clock.
- While reset is held, ops are ignored.
- An op sampled on the same edge on which reset is active is discarded.
- The first op is accepted on the first rising edge after `i_rst` deasserts.

## Structure
- Op-code constants (`NO_OP` … `NOT_OP`, 4 bits) live in a shared header, `alu_ops`. Controllers and benches include it; the RTL does not hard-code numeric codes.
- The module has one flat body: a combinational result mux feeding one WIDTH-bit register. No sub-module is needed.
- Use an optional `alu_shift` helper only if the shift/rotate group is reused elsewhere.

## Test plan
All scenarios use WIDTH = 8, with ops applied on consecutive cycles and each result checked on the following cycle.
- ADD 5, 8 → 13. Next cycle SUB 8, 13 → 0xFB (−5).
- AND 0xCC, 0xAA → 0x88. OR 0xAA, 0xCC → 0xEE. XOR 0xCA, 0xAC → 0x66.
- ROL 0x9A with arg1 = 0x86 → 0x35 (arg1 ignored). Then MUL 8, 13 → 104 (0x68). Then NO_OP → 104 is held.
- ROR 0x35 → 0x9A. LSL 0x81 → 0x02. LSR 0x81 → 0x40. ASR 0x81 → 0xC0. NOT 0x5A → 0xA5.
- Overflow wrap: ADD 0xFF, 0x01 → 0x00; MUL 0x10, 0x10 → 0x00; reserved op 0xE → previous value held.
- Reset: load 0x77, then assert `i_rst` mid-cycle. `o_data` = 0 before the next edge, and an ADD applied during reset is not reflected. After release, ADD 1, 2 → 3 one cycle later.

Source files
------------

// File: rtl/alu_core_pkg.sv
// Shared op-code definitions for alu_core.
// Controllers and benches import this package rather than hard-coding codes.
// Codes 0xD-0xF are reserved and decode as NO_OP (hold).
package alu_core_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] NO_OP  = 4'h0;
  localparam logic [OP_W-1:0] ADD_OP = 4'h1;
  localparam logic [OP_W-1:0] SUB_OP = 4'h2;
  localparam logic [OP_W-1:0] MUL_OP = 4'h3;
  localparam logic [OP_W-1:0] AND_OP = 4'h4;
  localparam logic [OP_W-1:0] OR_OP  = 4'h5;
  localparam logic [OP_W-1:0] XOR_OP = 4'h6;
  localparam logic [OP_W-1:0] ROL_OP = 4'h7;
  localparam logic [OP_W-1:0] ROR_OP = 4'h8;
  localparam logic [OP_W-1:0] LSL_OP = 4'h9;
  localparam logic [OP_W-1:0] LSR_OP = 4'hA;
  localparam logic [OP_W-1:0] ASR_OP = 4'hB;
  localparam logic [OP_W-1:0] NOT_OP = 4'hC;

endpackage

// File: rtl/alu_core.sv
// Single-cycle registered ALU.
// Ports:
//   i_clk  - system clock, rising edge active
//   i_rst  - asynchronous active-high reset, clears o_data
//   i_op   - 4-bit operation code (see alu_core_pkg)
//   i_arg0 - first operand, WIDTH bits
//   i_arg1 - second operand, WIDTH bits
//   o_data - registered result, valid one clock after the op is presented
module alu_core
  import alu_core_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [OP_W-1:0]  i_op,
  input  logic [WIDTH-1:0] i_arg0,
  input  logic [WIDTH-1:0] i_arg1,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Result mux; all arithmetic truncates to WIDTH bits (carry/overflow dropped).
  always_comb begin
    data_d = data_q;
    case (i_op)
      ADD_OP:  data_d = i_arg0 + i_arg1;
      SUB_OP:  data_d = i_arg0 - i_arg1;
      MUL_OP:  data_d = i_arg0 * i_arg1;
      AND_OP:  data_d = i_arg0 & i_arg1;
      OR_OP:   data_d = i_arg0 | i_arg1;
      XOR_OP:  data_d = i_arg0 ^ i_arg1;
      ROL_OP:  data_d = {i_arg0[WIDTH-2:0], i_arg0[WIDTH-1]};
      ROR_OP:  data_d = {i_arg0[0], i_arg0[WIDTH-1:1]};
      LSL_OP:  data_d = {i_arg0[WIDTH-2:0], 1'b0};
      LSR_OP:  data_d = {1'b0, i_arg0[WIDTH-1:1]};
      ASR_OP:  data_d = {i_arg0[WIDTH-1], i_arg0[WIDTH-1:1]};
      NOT_OP:  data_d = ~i_arg0;
      // NO_OP and reserved codes hold the previous result.
      default: data_d = data_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign o_data = data_q;

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core (WIDTH = 8): directed vector table,
// reset sequence, and randomized ops against an arithmetic reference model.
module tb_alu_core;
  import alu_core_pkg::*;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic [3:0]   op;
  logic [W-1:0] arg0;
  logic [W-1:0] arg1;
  logic [W-1:0] data;

  int checks = 0;
  int errors = 0;

  alu_core #(.WIDTH(W)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_op   (op),
    .i_arg0 (arg0),
    .i_arg1 (arg1),
    .o_data (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic [3:0] o, logic [7:0] a, logic [7:0] b,
                              logic [7:0] e);
    vec_t v;
    v.name = name;
    v.op   = o;
    v.a    = a;
    v.b    = b;
    v.exp  = e;
    return v;
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Present an op at the falling edge, let the rising edge capture it, sample 1 time unit later.
  task automatic apply(logic [3:0] o, logic [7:0] a, logic [7:0] b);
    @(negedge clk);
    op   = o;
    arg0 = a;
    arg1 = b;
    @(posedge clk);
    #1;
  endtask

  // Reference model built from plain integer arithmetic on 0..255 values.
  function automatic int model(int o, int a, int b, int prev);
    case (o)
      1:  return (a + b) % 256;
      2:  return (a - b + 256) % 256;
      3:  return (a * b) % 256;
      4:  return a & b;
      5:  return a | b;
      6:  return a ^ b;
      7:  return (a * 2) % 256 + a / 128;
      8:  return a / 2 + (a % 2) * 128;
      9:  return (a * 2) % 256;
      10: return a / 2;
      11: return a / 2 + ((a >= 128) ? 128 : 0);
      12: return 255 - a;
      default: return prev;
    endcase
  endfunction

  initial begin
    int         expv;
    logic [7:0] held;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [3:0] ro;

    rst  = 1'b1;
    op   = NO_OP;
    arg0 = '0;
    arg1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_value", data, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    vecs.push_back(mk("add_5_8",      ADD_OP, 8'h05, 8'h08, 8'h0D));
    vecs.push_back(mk("sub_8_13",     SUB_OP, 8'h08, 8'h0D, 8'hFB));
    vecs.push_back(mk("and",          AND_OP, 8'hCC, 8'hAA, 8'h88));
    vecs.push_back(mk("or",           OR_OP,  8'hAA, 8'hCC, 8'hEE));
    vecs.push_back(mk("xor",          XOR_OP, 8'hCA, 8'hAC, 8'h66));
    vecs.push_back(mk("rol",          ROL_OP, 8'h9A, 8'h86, 8'h35));
    vecs.push_back(mk("mul_8_13",     MUL_OP, 8'h08, 8'h0D, 8'h68));
    vecs.push_back(mk("noop_hold",    NO_OP,  8'h11, 8'h22, 8'h68));
    vecs.push_back(mk("ror",          ROR_OP, 8'h35, 8'hFF, 8'h9A));
    vecs.push_back(mk("lsl",          LSL_OP, 8'h81, 8'h00, 8'h02));
    vecs.push_back(mk("lsr",          LSR_OP, 8'h81, 8'h00, 8'h40));
    vecs.push_back(mk("asr",          ASR_OP, 8'h81, 8'h00, 8'hC0));
    vecs.push_back(mk("not",          NOT_OP, 8'h5A, 8'h3C, 8'hA5));
    vecs.push_back(mk("add_wrap",     ADD_OP, 8'hFF, 8'h01, 8'h00));
    vecs.push_back(mk("mul_wrap",     MUL_OP, 8'h10, 8'h10, 8'h00));
    vecs.push_back(mk("add_pre_rsv",  ADD_OP, 8'h12, 8'h21, 8'h33));
    vecs.push_back(mk("reserved_e",   4'hE,   8'hFF, 8'hFF, 8'h33));
    vecs.push_back(mk("reserved_d",   4'hD,   8'h01, 8'h02, 8'h33));
    vecs.push_back(mk("reserved_f",   4'hF,   8'h44, 8'h55, 8'h33));

    foreach (vecs[i]) begin
      apply(vecs[i].op, vecs[i].a, vecs[i].b);
      check(vecs[i].name, data, vecs[i].exp);
    end

    // Reset mid-cycle: clears immediately and swallows the op presented during reset.
    apply(ADD_OP, 8'h77, 8'h00);
    check("load_77", data, 8'h77);
    @(negedge clk);
    op   = ADD_OP;
    arg0 = 8'h01;
    arg1 = 8'h01;
    rst  = 1'b1;
    #1;
    check("rst_async_clear", data, 8'h00);
    @(posedge clk);
    #1;
    check("rst_op_ignored", data, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    apply(ADD_OP, 8'h01, 8'h02);
    check("post_rst_add", data, 8'h03);

    // Randomized ops; also wiggle inputs mid-cycle to confirm the output is register-only.
    held = data;
    for (int n = 0; n < 300; n++) begin
      ro = 4'($urandom_range(0, 15));
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      expv = model(int'(ro), int'(ra), int'(rb), int'(held));
      apply(ro, ra, rb);
      check($sformatf("rand_op%0h", ro), data, 8'(expv));
      held = 8'(expv);
      if (n % 10 == 0) begin
        #2;
        op   = ADD_OP;
        arg0 = ~ra;
        arg1 = 8'h5A;
        #1;
        check("no_comb_path", data, held);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out, got no finish expected finish");
    $fatal(1);
  end

endmodule
